// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches words over req/ack and hands them to decode over valid/ready.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned PC raises inst_fault instead of issuing a fetch.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] npc_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_o,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_o,
    output logic        inst_fault,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {FETCH, DRAIN, HOLD} state_t;

    state_t      state;
    state_t      state_next;
    logic        started;
    logic [31:0] pc;
    logic [31:0] drain_addr;
    logic [31:0] inst;
    logic [31:0] cnt;
    logic        fault;
    logic        misaligned;
    logic        fetch_live;
    logic        issue;
    logic        trap;
    logic [31:0] raw_addr;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // started holds off the first request until the cycle after reset is released
    assign fetch_live = (state == FETCH) && started;
    assign issue      = fetch_live && !misaligned;
    assign trap       = fetch_live && misaligned;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (issue) begin
                    if (imem_ack && !redirect_i) begin
                        state_next = HOLD;
                    end else if (!imem_ack && redirect_i) begin
                        state_next = DRAIN;
                    end
                end else if (trap && !redirect_i) begin
                    state_next = HOLD;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    state_next = FETCH;
                end
            end
            HOLD: begin
                if (redirect_i || inst_ready) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            started    <= 1'b0;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            inst       <= 32'h0;
            fault      <= 1'b0;
            cnt        <= 32'h0;
        end else begin
            started <= 1'b1;
            case (state)
                FETCH: begin
                    if (redirect_i) begin
                        pc <= redirect_pc_i;
                        // the abandoned request stays on the bus until memory answers it
                        if (issue && !imem_ack) begin
                            drain_addr <= pc;
                        end
                    end else if (issue && imem_ack) begin
                        inst  <= imem_rdata;
                        fault <= 1'b0;
                    end else if (trap) begin
                        inst  <= 32'h0;
                        fault <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (redirect_i) begin
                        pc <= redirect_pc_i;
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        pc    <= redirect_pc_i;
                        fault <= 1'b0;
                    end else if (inst_ready) begin
                        pc    <= npc_i;
                        cnt   <= cnt + 32'd1;
                        fault <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign raw_addr = (state == DRAIN) ? drain_addr : pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign imem_addr = raw_addr;
`else
    assign imem_addr = raw_addr & 32'hFFFF_FFFC;
`endif

    assign imem_req   = issue || (state == DRAIN);
    assign inst_valid = (state == HOLD);
    assign pc_o       = pc;
    assign inst_o     = inst;
    assign inst_fault = fault;
    assign fetch_cnt  = cnt;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of the fetch stage.
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] npc_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_o;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_o;
    logic        inst_fault;
    logic [31:0] fetch_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_wait = -1;
    logic [31:0] salt = 32'h0;

    // Model: what the stage is doing, in transaction terms
    logic        m_started;
    logic        m_have;
    logic        m_discard;
    logic        m_fault;
    logic [31:0] m_pc;
    logic [31:0] m_daddr;
    logic [31:0] m_inst;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rstn(rstn), .npc_i(npc_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_o(pc_o), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_o(inst_o), .inst_fault(inst_fault), .fetch_cnt(fetch_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_trap_now();
`ifdef FETCH_MISALIGN_TRAP_EN
        return m_pc[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_started = 0; m_have = 0; m_discard = 0; m_fault = 0;
        m_pc = RST_PC; m_daddr = RST_PC; m_inst = 0; m_cnt = 0;
    endtask

    task automatic compare_model();
        logic        exp_req;
        logic [31:0] exp_addr;
        exp_req  = m_started && !m_have && (m_discard || !m_trap_now());
        exp_addr = m_discard ? m_daddr : m_pc;
`ifndef FETCH_MISALIGN_TRAP_EN
        exp_addr[1:0] = 2'b00;
`endif
        checkOutput("pc_o", pc_o, m_pc);
        checkOutput("inst_valid", {31'h0, inst_valid}, {31'h0, m_have});
        checkOutput("inst_o", inst_o, m_inst);
        checkOutput("inst_fault", {31'h0, inst_fault}, {31'h0, m_fault});
        checkOutput("fetch_cnt", fetch_cnt, m_cnt);
        checkOutput("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
        if (!m_have) checkOutput("imem_addr", imem_addr, exp_addr);
    endtask

    task automatic model_step();
        if (!rstn) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1;
            if (redirect_i) m_pc = redirect_pc_i;
        end else if (m_have) begin
            if (redirect_i) begin
                m_pc = redirect_pc_i; m_have = 0; m_fault = 0;
            end else if (inst_ready) begin
                m_pc = npc_i; m_cnt = m_cnt + 1; m_have = 0; m_fault = 0;
            end
        end else if (m_discard) begin
            if (redirect_i) m_pc = redirect_pc_i;
            if (imem_ack) m_discard = 0;
        end else if (m_trap_now()) begin
            if (redirect_i) m_pc = redirect_pc_i;
            else begin m_inst = 0; m_fault = 1; m_have = 1; end
        end else begin
            if (imem_ack && redirect_i) m_pc = redirect_pc_i;
            else if (imem_ack) begin m_inst = imem_rdata; m_fault = 0; m_have = 1; end
            else if (redirect_i) begin m_discard = 1; m_daddr = m_pc; m_pc = redirect_pc_i; end
        end
    endtask

    // One cycle: check outputs against the model, drive inputs, play memory, advance the model
    task automatic applyStimulus(input bit rst_a, input bit redir, input logic [31:0] rpc,
                                 input bit rdy, input int lat, input bit use_npc, input logic [31:0] npc);
        @(negedge clk);
        compare_model();
        rstn          = !rst_a;
        redirect_i    = redir;
        redirect_pc_i = redir ? rpc : $urandom;
        inst_ready    = rdy;
        npc_i         = use_npc ? npc : m_pc + 32'd4;
        if (rst_a || !imem_req) begin
            mem_wait = -1;
            imem_ack = 1'b0;
        end else begin
            if (mem_wait < 0) mem_wait = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
            if (mem_wait == 0) begin imem_ack = 1'b1; mem_wait = -1; end
            else begin imem_ack = 1'b0; mem_wait--; end
        end
        imem_rdata = imem_ack ? ({imem_addr[15:0], 16'hC0DE} ^ salt) : $urandom;
        model_step();
    endtask

    task automatic step(input bit rdy, input int lat);
        applyStimulus(1'b0, 1'b0, 32'h0, rdy, lat, 1'b0, 32'h0);
    endtask

    initial begin
        rstn = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; inst_ready = 1'b0;
        npc_i = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        model_reset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 0, 1'b0, 32'h0);
        checkOutput("rst_pc", pc_o, 32'h0000_3000);
        checkOutput("rst_req", {31'h0, imem_req}, 32'h0);
        checkOutput("rst_addr", imem_addr, 32'h0000_3000);
        checkOutput("rst_cnt", fetch_cnt, 32'h0);
        checkOutput("rst_valid", {31'h0, inst_valid}, 32'h0);
        checkOutput("rst_inst", inst_o, 32'h0);

        // zero-wait memory, decode always ready
        for (int k = 1; k <= 7; k++) begin
            step(1'b1, 0);
            if (k == 1) checkOutput("first_cycle_req", {31'h0, imem_req}, 32'h0);
            if (k == 2) checkOutput("addr_3000", imem_addr, 32'h0000_3000);
            if (k == 3) checkOutput("inst_3000", inst_o, 32'h3000_C0DE);
            if (k == 4) checkOutput("addr_3004", imem_addr, 32'h0000_3004);
            if (k == 6) checkOutput("addr_3008", imem_addr, 32'h0000_3008);
        end
        // ack after 3 wait cycles, then decode stalls for 5 cycles
        for (int j = 0; j < 4; j++) begin
            step(1'b1, 3);
            checkOutput("slow_req", {31'h0, imem_req}, 32'h1);
            checkOutput("slow_addr", imem_addr, 32'h0000_300C);
            if (j == 0) checkOutput("cnt_3", fetch_cnt, 32'd3);
        end
        for (int j = 0; j < 5; j++) begin
            step(1'b0, 0);
            checkOutput("stall_inst", inst_o, 32'h300C_C0DE);
            checkOutput("stall_pc", pc_o, 32'h0000_300C);
            checkOutput("stall_req", {31'h0, imem_req}, 32'h0);
        end
        step(1'b1, 0);
        step(1'b0, 3);
        // redirect while waiting for ack
        applyStimulus(1'b0, 1'b1, 32'h0000_4180, 1'b0, 3, 1'b0, 32'h0);
        step(1'b0, 3);
        checkOutput("drain_addr", imem_addr, 32'h0000_3010);
        checkOutput("drain_pc", pc_o, 32'h0000_4180);
        step(1'b0, 3);
        step(1'b1, 0);
        checkOutput("redir_addr", imem_addr, 32'h0000_4180);
        checkOutput("redir_cnt", fetch_cnt, 32'd4);
        // redirect and ready together in HOLD
        applyStimulus(1'b0, 1'b1, 32'h0000_5000, 1'b1, 0, 1'b0, 32'h0);
        step(1'b1, 0);
        checkOutput("redir_hold_pc", pc_o, 32'h0000_5000);
        checkOutput("redir_hold_cnt", fetch_cnt, 32'd4);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 0, 1'b1, 32'h0000_5006);
        step(1'b1, 0);
        checkOutput("misal_pc", pc_o, 32'h0000_5006);
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("misal_req", {31'h0, imem_req}, 32'h0);
        step(1'b0, 0);
        checkOutput("misal_fault", {31'h0, inst_fault}, 32'h1);
        checkOutput("misal_inst", inst_o, 32'h0);
`else
        checkOutput("misal_req", {31'h0, imem_req}, 32'h1);
        checkOutput("misal_addr", imem_addr, 32'h0000_5004);
`endif

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            logic [31:0] tgt;
            logic [31:0] nxt;
            salt = $urandom;
            tgt  = $urandom & 32'h0000_FFFF;
            nxt  = $urandom & 32'h0000_FFFF;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) nxt[1:0] = 2'b00;
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0), tgt,
                          ($urandom_range(0, 9) < 6), -1, ($urandom_range(0, 9) == 0), nxt);
        end
        @(negedge clk);
        compare_model();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the single-cycle/multi-cycle MIPS core. Holds the architectural PC, issues word fetches to instruction memory over a req/ack handshake, and presents each fetched instruction to decode over a valid/ready handshake. It sits directly downstream of the next-PC logic: `pc_o` drives that logic's PC input, and its next-PC result returns on `npc_i`. A redirect input (exceptions, debug, external reset vector) overrides the PC and discards in-flight data.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `clk`  in  1  clock; all state changes on rising edge.
- `rstn`  in  1  synchronous active-low reset.
- `npc_i`  in  32  next PC from next-PC logic, computed from `pc_o`.
- `redirect_i`  in  1  force PC to `redirect_pc_i`, flush current instruction.
- `redirect_pc_i`  in  32  redirect target.
- `imem_req`  out  1  fetch request; held high until `imem_ack`.
- `imem_addr`  out  32  fetch address; stable while `imem_req` high.
- `imem_ack`  in  1  one-cycle response strobe; may assert in the first cycle of `imem_req`.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `pc_o`  out  32  current PC register.
- `inst_valid`  out  1  `inst_o` holds a valid instruction for decode.
- `inst_ready`  in  1  decode accepts `inst_o` this cycle.
- `inst_o`  out  32  instruction register.
- `inst_fault`  out  1  misaligned-fetch flag accompanying `inst_valid`.
- `fetch_cnt`  out  32  count of instructions accepted by decode.

## Operation
- States: FETCH, DRAIN, HOLD. Reset → FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc_o`.
  - On `imem_ack`: `inst_o`←`imem_rdata`, → HOLD.
  - On `imem_ack` with `redirect_i`: data discarded, PC←`redirect_pc_i`, stay in FETCH.
  - On `redirect_i` without `imem_ack`: PC←`redirect_pc_i`, → DRAIN.
- DRAIN: `imem_req` stays 1 with the old address latched in `imem_addr` until `imem_ack`. Response is discarded, then → FETCH. `redirect_i` in DRAIN updates PC only.
- HOLD: `inst_valid`=1, `imem_req`=0.
  - `inst_ready` without `redirect_i`: PC←`npc_i`, `fetch_cnt`+1 (wraps mod 2^32), → FETCH.
  - `redirect_i` has priority over `inst_ready`: PC←`redirect_pc_i`, no count, → FETCH.
- `inst_valid` is 1 only in HOLD. `inst_o` is stable throughout HOLD.
- Reset outputs: `pc_o`=RESET_PC, `imem_req`=0, `imem_addr`=RESET_PC, `inst_valid`=0, `inst_o`=0, `inst_fault`=0, `fetch_cnt`=0.
- Reset mid-transaction abandons any outstanding request. Memory must tolerate a dropped req.

## Timing
- All outputs are registered except `imem_req`, `inst_valid` and `imem_addr`, which are decoded from state and registers with no input-to-output combinational path.
- `imem_req` rises in the first cycle after `rstn` deasserts.
- Throughput, zero-wait memory and ready decode: 2 cycles per instruction (FETCH, HOLD).
- `npc_i` is sampled only in the HOLD cycle where `inst_ready`=1. It must be valid combinationally from `pc_o` in that cycle.
- A redirect taking effect at edge N produces `imem_addr`=`redirect_pc_i` in cycle N+1, unless the FSM is in DRAIN.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - In FETCH with `pc_o[1:0]`≠0, no request is issued.
  - Next edge: `inst_o`←0, `inst_fault`←1, → HOLD.
  - `inst_fault` clears on leaving HOLD.
- Not defined:
  - `imem_addr[1:0]` forced to 2'b00.
  - `inst_fault` tied 0.
  - No other behaviour changes.

## Test plan
- Reset release, memory acks same cycle, `inst_ready`=1, `npc_i`=`pc_o`+4 → `imem_addr` 0x3000, 0x3004, 0x3008 on alternating cycles; `fetch_cnt`=3 after 6 cycles.
- Ack delayed 3 cycles → `imem_req` held with `imem_addr` stable for 4 cycles; `inst_o`=`imem_rdata` in HOLD.
- `inst_ready` low for 5 cycles in HOLD → `inst_valid` and `inst_o` unchanged, `pc_o` unchanged, no `imem_req`.
- `redirect_i` to 0x0000_4180 while waiting for ack → DRAIN; old response discarded; next request at 0x4180; `fetch_cnt` unchanged.
- `redirect_i` and `inst_ready` together in HOLD → PC=`redirect_pc_i`, not `npc_i`; no count increment.
- With `FETCH_MISALIGN_TRAP_EN` defined, `npc_i`=0x3006 → no req at 0x3006; `inst_valid`=1, `inst_fault`=1, `inst_o`=0. Without the macro, the req goes out at 0x3004.
